// File: rtl/vram_console_writer_if.sv
// Byte-stream handshake into the console writer.
// The sender holds char_data while char_valid && !char_ready.
interface vram_console_writer_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/vram_console_writer.sv
// Console writer: puts characters into the text buffer, tracks the
// cursor and runs hardware scroll/clear through the VRAM write port.
module vram_console_writer #(
  parameter int       VRAM_BASE = 'h1000,
  parameter int       TEXTCOL   = 64,
  parameter int       TEXTROW   = 37,
  parameter int       ADDRW     = 15,
  parameter bit [7:0] BLANK     = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vram_console_writer_if.slave cin,
  output logic [ADDRW-1:0]     vid_address,
  output logic [7:0]           vid_wdata,
  output logic                 vid_we,
  input  logic [7:0]           vid_rdata,
  output logic [5:0]           cursor_col,
  output logic [5:0]           cursor_row,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_t;

  localparam int CELLS    = TEXTCOL * TEXTROW;
  localparam int SCROLL_N = (TEXTROW - 1) * TEXTCOL;

  localparam logic [ADDRW-1:0] BASE =
    ADDRW'(VRAM_BASE);
  localparam logic [ADDRW-1:0] ROW1 =
    ADDRW'(VRAM_BASE + TEXTCOL);
  localparam logic [ADDRW-1:0] LROW =
    ADDRW'(VRAM_BASE + SCROLL_N);

  localparam logic [5:0]  LAST_COL = 6'(TEXTCOL - 1);
  localparam logic [5:0]  LAST_ROW = 6'(TEXTROW - 1);
  localparam logic [11:0] IDX_LAST = 12'(SCROLL_N - 1);
  localparam logic [11:0] CELLS_N  = 12'(CELLS);
  localparam logic [11:0] ROW_N    = 12'(TEXTCOL);

  state_t           state_q, state_d;
  logic [5:0]       col_q, col_d;
  logic [5:0]       row_q, row_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [11:0]      idx_q, idx_d;
  logic [11:0]      cnt_q, cnt_d;

  logic             accept;
  logic             nl;
  logic             is_print;
  logic [7:0]       ch;
  logic [ADDRW-1:0] cell_addr;

  assign ch       = cin.char_data;
  assign accept   = cin.char_valid && (state_q == IDLE);
  assign is_print = (ch >= 8'h20) && (ch <= 8'h7E);

  assign cell_addr = BASE
    + ADDRW'(row_q) * ADDRW'(TEXTCOL)
    + ADDRW'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nl      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_print: begin
              state_d = PUT;
              we_d    = 1'b1;
              addr_d  = cell_addr;
              wdata_d = ch;
            end
            ch == 8'h0D: col_d = '0;
            ch == 8'h0A: nl = 1'b1;
            ch == 8'h08: begin
              if (col_q != '0) col_d = col_q - 6'd1;
            end
            ch == 8'h0C: begin
              col_d   = '0;
              row_d   = '0;
              state_d = FILL;
              we_d    = 1'b1;
              addr_d  = BASE;
              wdata_d = BLANK;
              cnt_d   = CELLS_N;
            end
            default: ;
          endcase
        end
      end
      PUT: begin
        state_d = IDLE;
        if (col_q == LAST_COL) begin
          col_d = '0;
          nl    = 1'b1;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      SCROLL_RD: begin
        state_d = SCROLL_WR;
        we_d    = 1'b1;
        addr_d  = BASE + ADDRW'(idx_q);
      end
      SCROLL_WR: begin
        if (idx_q == IDX_LAST) begin
          state_d = FILL;
          we_d    = 1'b1;
          addr_d  = LROW;
          wdata_d = BLANK;
          cnt_d   = ROW_N;
        end else begin
          state_d = SCROLL_RD;
          idx_d   = idx_q + 12'd1;
          addr_d  = ROW1 + ADDRW'(idx_q + 12'd1);
        end
      end
      FILL: begin
        if (cnt_q == 12'd1) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          cnt_d  = cnt_q - 12'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Newline on the last row starts a scroll instead of moving down.
    if (nl) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + 6'd1;
      end else begin
        col_d   = '0;
        idx_d   = '0;
        state_d = SCROLL_RD;
        addr_d  = ROW1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= BASE;
      wdata_q <= BLANK;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Copy data arrives one cycle after the read address, in SCROLL_WR.
  assign vid_wdata = (state_q == SCROLL_WR) ? vid_rdata : wdata_q;

  assign vid_address    = addr_q;
  assign vid_we         = we_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign cin.char_ready = (state_q == IDLE);
  assign busy           = (state_q == SCROLL_RD)
                       || (state_q == SCROLL_WR)
                       || (state_q == FILL);

endmodule

// File: tb/tb_vram_console_writer.sv
// Directed bench for vram_console_writer with a 1-cycle-read VRAM model.
// Expected screen contents come from a closed-form pattern.
module tb_vram_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] vid_address;
  logic [7:0]  vid_wdata;
  logic        vid_we;
  logic [7:0]  vid_rdata = 8'h00;
  logic [5:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  vram_console_writer_if cif ();

  vram_console_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cin         (cif),
    .vid_address (vid_address),
    .vid_wdata   (vid_wdata),
    .vid_we      (vid_we),
    .vid_rdata   (vid_rdata),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  logic [7:0]  mem [0:32767];
  int          wr_cnt   = 0;
  int          busy_cyc = 0;
  int          oor_cnt  = 0;
  int          seq_err  = 0;
  int          we_idle  = 0;
  logic        run      = 1'b0;
  logic [14:0] last_a   = '0;

  // VRAM model plus bus monitors.
  always @(posedge clk) begin
    if (vid_we) mem[vid_address] <= vid_wdata;
    vid_rdata <= mem[vid_address];
    if (vid_we) wr_cnt <= wr_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if ((vid_we || busy) &&
        (vid_address < 15'h1000 || vid_address > 15'h193F))
      oor_cnt <= oor_cnt + 1;
    if (vid_we && cif.char_ready) we_idle <= we_idle + 1;
    if (vid_we && busy) begin
      if (run && vid_address != last_a + 15'd1)
        seq_err <= seq_err + 1;
      if (!run && vid_address != 15'h1000)
        seq_err <= seq_err + 1;
      last_a <= vid_address;
      run    <= 1'b1;
    end
    if (!busy) run <= 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    cif.char_valid = 1'b1;
    cif.char_data  = b;
    while (!cif.char_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cif.char_ready) chk("send_timeout", {31'd0, cif.char_ready}, 1);
    @(posedge clk);
    #1;
    cif.char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!cif.char_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!cif.char_ready) chk("idle_timeout", {31'd0, cif.char_ready}, 1);
  endtask

  function automatic logic [7:0] pat(int r, int c);
    return 8'h21 + 8'((r * 7 + c) % 94);
  endfunction

  // Mismatches after k scrolls of a pattern-filled screen.
  function automatic int scroll_mism(int k);
    int m;
    logic [7:0] e;
    m = 0;
    for (int r = 0; r < 37; r++)
      for (int c = 0; c < 64; c++) begin
        e = (r + k <= 36) ? pat(r + k, c) : 8'h20;
        if (mem[32'h1000 + r * 64 + c] !== e) m++;
      end
    return m;
  endfunction

  function automatic int blank_mism(int skip0);
    int m;
    m = 0;
    for (int i = skip0; i < 2368; i++)
      if (mem[32'h1000 + i] !== 8'h20) m++;
    return m;
  endfunction

  initial begin
    int b0;
    int w0;
    int n;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_we", vid_we, 0);
    chk("rst_addr", vid_address, 32'h1000);
    chk("rst_wdata", vid_wdata, 32'h20);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", cif.char_ready, 1);

    // 1: single printable
    send(8'h41);
    chk("t1_we", vid_we, 1);
    chk("t1_addr", vid_address, 32'h1000);
    chk("t1_wdata", vid_wdata, 32'h41);
    chk("t1_ready0", cif.char_ready, 0);
    @(posedge clk);
    #1;
    chk("t1_col", cursor_col, 1);
    chk("t1_row", cursor_row, 0);
    chk("t1_ready1", cif.char_ready, 1);
    chk("t1_we0", vid_we, 0);

    // Clear screen
    b0 = busy_cyc;
    w0 = wr_cnt;
    send(8'h0C);
    wait_idle();
    chk("ff_busy", busy_cyc - b0, 2368);
    chk("ff_writes", wr_cnt - w0, 2368);
    chk("ff_blank", blank_mism(0), 0);
    chk("ff_cursor", {cursor_row, cursor_col}, 0);

    // 2: control characters at (10,5)
    repeat (5) send(8'h0A);
    repeat (10) send(8'h78);
    @(posedge clk);
    #1;
    chk("t2_col", cursor_col, 10);
    chk("t2_row", cursor_row, 5);
    chk("t2_mem", mem[32'h1000 + 5 * 64 + 9], 32'h78);
    w0 = wr_cnt;
    send(8'h0D);
    chk("t2_cr", {cursor_row, cursor_col}, {6'd5, 6'd0});
    send(8'h0A);
    chk("t2_lf", {cursor_row, cursor_col}, {6'd6, 6'd0});
    send(8'h08);
    chk("t2_bs0", {cursor_row, cursor_col}, {6'd6, 6'd0});
    send(8'h01);
    @(posedge clk);
    #1;
    chk("t2_nowrite", wr_cnt - w0, 0);
    send(8'h61);
    send(8'h62);
    send(8'h08);
    chk("t2_bs", {cursor_row, cursor_col}, {6'd6, 6'd1});

    // 3: full row 0
    send(8'h0C);
    wait_idle();
    for (int i = 0; i < 64; i++) send(8'h21 + 8'(i));
    chk("t3_addr", vid_address, 32'h103F);
    chk("t3_wdata", vid_wdata, 32'h60);
    chk("t3_we", vid_we, 1);
    @(posedge clk);
    #1;
    chk("t3_cursor", {cursor_row, cursor_col}, {6'd1, 6'd0});
    chk("t3_mem0", mem[32'h1000], 32'h21);
    chk("t3_mem63", mem[32'h103F], 32'h60);

    // 4: scroll via line wrap, then via LF
    send(8'h0C);
    wait_idle();
    for (int r = 0; r < 37; r++)
      for (int c = 0; c < 64; c++)
        if (!(r == 36 && c == 63)) send(pat(r, c));
    @(posedge clk);
    #1;
    chk("t4_pre_cur", {cursor_row, cursor_col}, {6'd36, 6'd63});
    b0 = busy_cyc;
    send(pat(36, 63));
    chk("t4_put_addr", vid_address, 32'h193F);
    @(posedge clk);
    #1;
    chk("t4_busy", busy, 1);
    chk("t4_rdy", cif.char_ready, 0);
    chk("t4_cur", {cursor_row, cursor_col}, {6'd36, 6'd0});
    wait_idle();
    chk("t4_cycles1", busy_cyc - b0, 4672);
    chk("t4_mem1", scroll_mism(1), 0);
    b0 = busy_cyc;
    send(8'h0A);
    wait_idle();
    chk("t4_cycles2", busy_cyc - b0, 4672);
    chk("t4_mem2", scroll_mism(2), 0);
    chk("t4_cur2", {cursor_row, cursor_col}, {6'd36, 6'd0});

    // 5: clear with a byte held during busy
    b0 = busy_cyc;
    w0 = wr_cnt;
    send(8'h0C);
    cif.char_valid = 1'b1;
    cif.char_data  = 8'h5A;
    n = 0;
    @(negedge clk);
    while (!cif.char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_held", busy_cyc - b0, 2368);
    chk("t5_fillw", wr_cnt - w0, 2368);
    @(posedge clk);
    #1;
    cif.char_valid = 1'b0;
    chk("t5_we", vid_we, 1);
    chk("t5_addr", vid_address, 32'h1000);
    chk("t5_wdata", vid_wdata, 32'h5A);
    @(posedge clk);
    #1;
    chk("t5_cur", {cursor_row, cursor_col}, {6'd0, 6'd1});
    chk("t5_blank", blank_mism(1), 0);
    chk("t5_z", mem[32'h1000], 32'h5A);

    // 6: reset in the middle of a scroll
    send(8'h0D);
    repeat (36) send(8'h0A);
    chk("t6_pre", {cursor_row, cursor_col}, {6'd36, 6'd0});
    send(8'h0A);
    repeat (1000) @(posedge clk);
    #2;
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we", vid_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cur", {cursor_row, cursor_col}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ready", cif.char_ready, 1);
    send(8'h42);
    chk("t6_addr", vid_address, 32'h1000);
    chk("t6_wdata", vid_wdata, 32'h42);

    // Bus-wide invariants
    @(posedge clk);
    #1;
    chk("oor", oor_cnt, 0);
    chk("seq", seq_err, 0);
    chk("we_idle", we_idle, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_console_writer.md
Name: vram_console_writer

Overview:
- Writer end of the character video RAM that the character-mode PPU reads.
- Accepts a byte stream (CPU/UART side) via valid/ready and writes characters into the 64x37 text buffer at VRAM 0x1000.
- Maintains the cursor and interprets CR, LF, BS and FF.
- Performs hardware scroll and clear using the VRAM write port plus a read-back port. The PPU keeps its own read port on the dual-ported VRAM.

Parameters:
- VRAM_BASE, 'h1000, byte address of text cell (0,0).
- TEXTCOL, 64, characters per row.
- TEXTROW, 37, rows on screen.
- ADDRW, 15, VRAM address width.
- BLANK, 8'h20, fill character for clear and scroll.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- char_valid  input  1  char_data valid.
- char_data  input  8  incoming byte.
- char_ready  output  1  block can accept a byte this cycle.
- vid_address  output  ADDRW  VRAM address for read or write.
- vid_wdata  output  8  VRAM write data.
- vid_we  output  1  VRAM write strobe, one cycle per write.
- vid_rdata  input  8  VRAM read data, valid 1 cycle after vid_address is presented with vid_we=0.
- cursor_col  output  6  current column, 0..TEXTCOL-1.
- cursor_row  output  6  current row, 0..TEXTROW-1.
- busy  output  1  scroll or clear in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cursor_col=0; cursor_row=0; vid_we=0; vid_address=VRAM_BASE; vid_wdata=BLANK; busy=0.
  - char_ready=1 after reset release.
  - Screen contents are not cleared.
- Handshake:
  - A byte is accepted on the rising edge where char_valid && char_ready.
  - char_ready=1 only in IDLE.
  - char_data must be held while valid && !ready.
- Registered outputs; cell address = VRAM_BASE + row*TEXTCOL + col (row*64 is a shift).
- States: IDLE, PUT, SCROLL_RD, SCROLL_WR, FILL.
- IDLE, on accept:
  - 0x20..0x7E: latch char and address, go to PUT.
  - 0x0D (CR): col=0, stay IDLE.
  - 0x0A (LF): newline (see below), stay IDLE unless scroll starts.
  - 0x08 (BS): col=col-1 if col>0, else no change. No erase.
  - 0x0C (FF): cursor=(0,0), fill index=0, fill count=TEXTCOL*TEXTROW (2368), go to FILL.
  - All other bytes: consumed, no effect.
- PUT (1 cycle):
  - vid_we=1, vid_wdata=char, vid_address=cell(row,col).
  - Then advance the cursor: col<63 gives col+1; col=63 gives col=0 and newline.
  - Return to IDLE, or to SCROLL_RD if the newline scrolls.
- Newline:
  - row<36: row+1.
  - row=36: row stays 36, col=0, start scroll with index i=0.
- Scroll copy, i = 0..(TEXTROW-1)*TEXTCOL-1 (0..2303):
  - SCROLL_RD: vid_we=0, vid_address=VRAM_BASE+TEXTCOL+i.
  - SCROLL_WR: vid_we=1, vid_address=VRAM_BASE+i, vid_wdata=vid_rdata.
  - After i=2303, go to FILL with start VRAM_BASE+36*64 and count 64.
- FILL:
  - One write per cycle: vid_we=1, vid_wdata=BLANK, address increments from the start address.
  - Return to IDLE after count writes.
- busy=1 in SCROLL_RD, SCROLL_WR and FILL; char_ready=0 during these states.
- Cycle counts:
  - Scroll = 2*2304 + 64 = 4672 cycles.
  - Clear = 2368 cycles.
- char_valid while busy: ignored; the byte is held by the sender until ready.
- No VRAM access outside VRAM_BASE .. VRAM_BASE+2367.
- Reset mid-scroll or mid-fill: immediate return to IDLE, vid_we=0, cursor=(0,0). Partial VRAM contents are left as-is.
- vid_we is never high in IDLE.

Test Plan:
1. After reset, send 'A' (0x41) -> one cycle later vid_we=1, vid_address=0x1000, vid_wdata=0x41; cursor=(1,0); char_ready back to 1 after 2 cycles.
2. Cursor at (10,5), send 0x0D then 0x0A then 0x08 -> cursor (0,5), then (0,6), then (0,6). No vid_we pulses.
3. Fill row 0 with 64 printable chars -> last write at 0x103F; cursor=(0,1).
4. Preload VRAM (model with 1-cycle read), cursor at (0,36), send LF -> busy for 4672 cycles. Row r receives old row r+1 for r=0..35. Row 36 (0x1900..0x193F) = 0x20. Cursor=(0,36).
5. Send 0x0C -> 2368 consecutive writes of 0x20 at 0x1000..0x193F; cursor=(0,0). char_valid asserted during busy is not accepted until busy=0.
6. Assert rst_n=0 at cycle 1000 of a scroll -> vid_we=0 and state IDLE immediately. After release: char_ready=1, cursor=(0,0).
